// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq -- boot-time AHB-Lite master that brings up the PLL.
//
// Sequence after i_start: write the divider word, enable the PLL, poll the
// lock bit (up to POLL_MAX reads), then switch the SoC clock to pll_clk.
// A bus ERROR response or a lock timeout aborts the sequence without
// touching the clock-select register, so the SoC stays on xo_clk.
//
// Ports:
//   i_clk_ahb, i_rstn_ahb   AHB clock, asynchronous active-low reset
//   i_start                 one-cycle pulse, honoured only in IDLE
//   i_div_cfg               divider word, latched on i_start
//   o_busy                  sequence in progress
//   o_done/o_err/o_timeout  sticky status, cleared by the next i_start
//   o_h*/i_h*               AHB-Lite master interface (single NONSEQ only)
//   o_dbg_state             current FSM state, for debug and checkers
//
// Handshake: a transfer's address phase is presented with o_htrans = NONSEQ
// and is accepted on the first rising edge where i_hready = 1. The data phase
// follows and ends on the next rising edge with i_hready = 1; read data and
// the response are taken on that edge. i_hresp = 1 while i_hready = 0 is the
// first cycle of an ERROR response. Only one transfer is ever outstanding and
// every transfer is followed by one IDLE cycle.
module pll_cfg_seq #(
  parameter logic [31:0] PLL_BASE = 32'h4000_0000,
  parameter logic [7:0]  DIV_OFS  = 8'h04,
  parameter logic [7:0]  CTRL_OFS = 8'h00,
  parameter logic [7:0]  STAT_OFS = 8'h08,
  parameter logic [7:0]  SEL_OFS  = 8'h0C,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        i_clk_ahb,
  input  logic        i_rstn_ahb,
  input  logic        i_start,
  input  logic [31:0] i_div_cfg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_timeout,
  output logic [31:0] o_haddr,
  output logic [1:0]  o_htrans,
  output logic        o_hwrite,
  output logic [2:0]  o_hsize,
  output logic [2:0]  o_hburst,
  output logic [3:0]  o_hprot,
  output logic        o_hmastlock,
  output logic [31:0] o_hwdata,
  input  logic        i_hready,
  input  logic        i_hresp,
  input  logic [31:0] i_hrdata,
  output logic [2:0]  o_dbg_state
);

  localparam int CW = $clog2(POLL_MAX + 1);
  localparam logic [CW-1:0] POLL_LIM = CW'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DIV  = 3'd1,
    S_WR_EN   = 3'd2,
    S_RD_STAT = 3'd3,
    S_WR_SEL  = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  // Sub-phase inside each bus state: address, data, then one idle cycle.
  typedef enum logic [1:0] {
    P_ADDR = 2'd0,
    P_DATA = 2'd1,
    P_GAP  = 2'd2
  } phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [31:0]   div_q;
  logic [CW-1:0] poll_cnt, poll_inc;
  logic          lock_q;
  logic          err_pend;
  logic          bus_state;
  logic          start_seq, rd_done, to_err, set_timeout, set_done;
  logic [31:0]   addr_cur, wdata_cur;
  logic          is_write;
  logic          unused_hrdata;

  assign unused_hrdata = ^i_hrdata[31:1];

  assign bus_state = (state == S_WR_DIV) || (state == S_WR_EN) ||
                     (state == S_RD_STAT) || (state == S_WR_SEL);

  // Saturating increment so the counter can never wrap back to zero.
  assign poll_inc = (poll_cnt == POLL_LIM) ? poll_cnt : poll_cnt + 1'b1;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state <= S_IDLE;
      phase <= P_ADDR;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    start_seq   = 1'b0;
    rd_done     = 1'b0;
    to_err      = 1'b0;
    set_timeout = 1'b0;
    set_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_n   = S_WR_DIV;
          phase_n   = P_ADDR;
          start_seq = 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        state_n = S_IDLE;
        phase_n = P_ADDR;
      end
      default: begin
        case (phase)
          P_ADDR: begin
            if (i_hready) phase_n = P_DATA;
          end
          P_DATA: begin
            if (i_hready) begin
              // A response flagged in an earlier wait cycle or on the
              // completing edge itself both abort the sequence.
              if (err_pend || i_hresp) begin
                state_n = S_ERR;
                phase_n = P_ADDR;
                to_err  = 1'b1;
              end else if (state == S_RD_STAT) begin
                rd_done = 1'b1;
                if (!i_hrdata[0] && (poll_inc == POLL_LIM)) begin
                  state_n     = S_ERR;
                  phase_n     = P_ADDR;
                  to_err      = 1'b1;
                  set_timeout = 1'b1;
                end else begin
                  phase_n = P_GAP;
                end
              end else begin
                phase_n = P_GAP;
              end
            end
          end
          P_GAP: begin
            phase_n = P_ADDR;
            case (state)
              S_WR_DIV:  state_n = S_WR_EN;
              S_WR_EN:   state_n = S_RD_STAT;
              S_RD_STAT: state_n = lock_q ? S_WR_SEL : S_RD_STAT;
              S_WR_SEL: begin
                state_n  = S_DONE;
                set_done = 1'b1;
              end
              default:   state_n = S_IDLE;
            endcase
          end
          default: phase_n = P_ADDR;
        endcase
      end
    endcase
  end

  always_comb begin
    addr_cur  = 32'h0;
    wdata_cur = 32'h0;
    is_write  = 1'b0;
    case (state)
      S_WR_DIV: begin
        addr_cur  = PLL_BASE + {24'h0, DIV_OFS};
        wdata_cur = div_q;
        is_write  = 1'b1;
      end
      S_WR_EN: begin
        addr_cur  = PLL_BASE + {24'h0, CTRL_OFS};
        wdata_cur = 32'h1;
        is_write  = 1'b1;
      end
      S_RD_STAT: begin
        addr_cur  = PLL_BASE + {24'h0, STAT_OFS};
      end
      S_WR_SEL: begin
        addr_cur  = PLL_BASE + {24'h0, SEL_OFS};
        wdata_cur = 32'h0;
        is_write  = 1'b1;
      end
      default: begin
        addr_cur  = 32'h0;
      end
    endcase
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      div_q     <= 32'h0;
      poll_cnt  <= '0;
      lock_q    <= 1'b0;
      err_pend  <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      o_hwdata  <= 32'h0;
    end else begin
      if (start_seq) begin
        div_q     <= i_div_cfg;
        poll_cnt  <= '0;
        lock_q    <= 1'b0;
        err_pend  <= 1'b0;
        o_done    <= 1'b0;
        o_err     <= 1'b0;
        o_timeout <= 1'b0;
      end
      if (bus_state && (phase == P_DATA) && !i_hready && i_hresp) begin
        err_pend <= 1'b1;
      end
      if (rd_done) begin
        poll_cnt <= poll_inc;
        lock_q   <= i_hrdata[0];
      end
      if (to_err)      o_err     <= 1'b1;
      if (set_timeout) o_timeout <= 1'b1;
      if (set_done)    o_done    <= 1'b1;
      // Write data is loaded as the address phase is accepted and then held
      // for the whole data phase, however long the slave stretches it.
      if (bus_state && (phase == P_ADDR) && i_hready && is_write) begin
        o_hwdata <= wdata_cur;
      end
    end
  end

  assign o_busy      = bus_state;
  assign o_htrans    = (bus_state && (phase == P_ADDR)) ? 2'b10 : 2'b00;
  assign o_haddr     = (bus_state && (phase == P_ADDR)) ? addr_cur : 32'h0;
  assign o_hwrite    = bus_state && (phase == P_ADDR) && is_write;
  assign o_hsize     = 3'b010;
  assign o_hburst    = 3'b000;
  assign o_hprot     = 4'b0011;
  assign o_hmastlock = 1'b0;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb_pll_cfg_seq -- directed bench for pll_cfg_seq.
// A small AHB slave model answers the DUT (lock after lock_n reads, 0 = never);
// a bus monitor logs address phases, write addresses/data and status reads.
module tb_pll_cfg_seq;

  localparam logic [31:0] A_CTRL = 32'h4000_0000;
  localparam logic [31:0] A_DIV  = 32'h4000_0004;
  localparam logic [31:0] A_STAT = 32'h4000_0008;
  localparam logic [31:0] A_SEL  = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] div_cfg = 32'h0;
  logic        busy, done, err, timeout;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hmastlock;
  logic [2:0]  hsize, hburst, dbg_state;
  logic [3:0]  hprot;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  // Slave / monitor state
  int          lock_n = 1;
  logic        clr = 1'b0;
  int          n_addr = 0, n_wr = 0, n_rd = 0, dph_idx = 0;
  logic        dph = 1'b0, dph_wr = 1'b0;
  logic [31:0] dph_addr = 32'h0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic        hr_lock;

  pll_cfg_seq dut (
    .i_clk_ahb   (clk),
    .i_rstn_ahb  (rst_n),
    .i_start     (start),
    .i_div_cfg   (div_cfg),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_timeout   (timeout),
    .o_haddr     (haddr),
    .o_htrans    (htrans),
    .o_hwrite    (hwrite),
    .o_hsize     (hsize),
    .o_hburst    (hburst),
    .o_hprot     (hprot),
    .o_hmastlock (hmastlock),
    .o_hwdata    (hwdata),
    .i_hready    (hready),
    .i_hresp     (hresp),
    .i_hrdata    (hrdata),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // The read in flight is read number n_rd+1.
  always_comb hr_lock = (lock_n != 0) && ((n_rd + 1) >= lock_n);
  assign hrdata = {31'h0, hr_lock};

  always @(posedge clk) begin
    if (!rst_n || clr) begin
      dph    <= 1'b0;
      n_addr <= 0;
      n_wr   <= 0;
      n_rd   <= 0;
    end else begin
      if (dph && hready) begin
        dph <= 1'b0;
        if (dph_wr) wr_data[dph_idx] <= hwdata;
        else if (dph_addr == A_STAT) n_rd <= n_rd + 1;
      end
      if (htrans == 2'b10 && hready) begin
        n_addr   <= n_addr + 1;
        dph      <= 1'b1;
        dph_wr   <= hwrite;
        dph_addr <= haddr;
        if (hwrite && n_wr < 16) begin
          wr_addr[n_wr] <= haddr;
          dph_idx       <= n_wr;
          n_wr          <= n_wr + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Pulse i_start, then count negedges until done or err (or budget).
  task automatic run_seq(input logic [31:0] div, input int budget, output int cyc);
    @(negedge clk);
    start   = 1'b1;
    div_cfg = div;
    cyc     = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!(done || err) && cyc < budget);
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget, output logic ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < budget) begin
      @(negedge clk);
      k++;
      if (htrans == 2'b10 && haddr == a) ok = 1'b1;
    end
  endtask

  initial begin
    int   cyc;
    logic ok;

    // ---- reset values
    repeat (3) @(negedge clk);
    check("rst_htrans", {30'h0, htrans}, 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", {31'h0, hwrite}, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_flags", {28'h0, busy, done, err, timeout}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    check("const_attr", {20'h0, hsize, hburst, hprot, 1'b0, hmastlock}, {20'h0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- 1: zero-wait, lock on first read
    lock_n = 1;
    clear_logs();
    run_seq(32'h0000_0A05, 100, cyc);
    check("s1_cycles", cyc, 13);
    check("s1_done", {31'h0, done}, 32'h1);
    check("s1_err_busy", {30'h0, err, busy}, 32'h0);
    check("s1_nwr", n_wr, 3);
    check("s1_nrd", n_rd, 1);
    check("s1_wa0", wr_addr[0], A_DIV);
    check("s1_wd0", wr_data[0], 32'h0000_0A05);
    check("s1_wa1", wr_addr[1], A_CTRL);
    check("s1_wd1", wr_data[1], 32'h1);
    check("s1_wa2", wr_addr[2], A_SEL);
    check("s1_wd2", wr_data[2], 32'h0);

    // ---- 2: lock on 5th read
    lock_n = 5;
    clear_logs();
    run_seq(32'h1234_5678, 200, cyc);
    check("s2_cycles", cyc, 25);
    check("s2_done", {30'h0, done, err}, 32'h2);
    check("s2_nrd", n_rd, 5);
    check("s2_nwr", n_wr, 3);
    check("s2_wd0", wr_data[0], 32'h1234_5678);
    check("s2_wa2", wr_addr[2], A_SEL);

    // ---- 3: lock never set -> timeout after POLL_MAX reads
    lock_n = 0;
    clear_logs();
    run_seq(32'h0000_0001, 5000, cyc);
    repeat (2) @(negedge clk);
    check("s3_nrd", n_rd, 1024);
    check("s3_flags", {29'h0, done, err, timeout}, 32'h3);
    check("s3_busy", {31'h0, busy}, 32'h0);
    check("s3_nwr", n_wr, 2);

    // ---- 4: 3-cycle stall in WR_EN address phase
    lock_n = 1;
    clear_logs();
    fork
      run_seq(32'h0000_0A05, 100, cyc);
      begin
        wait_addr(A_CTRL, 50, ok);
        check("s4_seen", {31'h0, ok}, 32'h1);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("s4_stall_addr", haddr, A_CTRL);
          check("s4_stall_trans", {30'h0, htrans}, 32'h2);
        end
        hready = 1'b1;
      end
    join
    check("s4_cycles", cyc, 16);
    check("s4_done", {30'h0, done, err}, 32'h2);
    check("s4_nwr", n_wr, 3);
    check("s4_wa1", wr_addr[1], A_CTRL);
    check("s4_wd1", wr_data[1], 32'h1);

    // ---- 5: two-cycle ERROR on WR_DIV data phase
    clear_logs();
    fork
      run_seq(32'h0000_0A05, 100, cyc);
      begin
        wait_addr(A_DIV, 50, ok);
        check("s5_seen", {31'h0, ok}, 32'h1);
        @(negedge clk);
        hready = 1'b0;
        hresp  = 1'b1;
        @(negedge clk);
        hready = 1'b1;
        @(negedge clk);
        hresp  = 1'b0;
      end
    join
    check("s5_flags", {28'h0, busy, done, err, timeout}, 32'h2);
    repeat (20) @(negedge clk);
    check("s5_naddr", n_addr, 1);
    check("s5_idle", {30'h0, htrans}, 32'h0);
    check("s5_sticky", {30'h0, busy, err}, 32'h1);

    // ---- 6: async reset during RD_STAT, then clean rerun
    lock_n = 0;
    clear_logs();
    @(negedge clk);
    start   = 1'b1;
    div_cfg = 32'hDEAD_BEEF;
    @(negedge clk);
    start   = 1'b0;
    wait_addr(A_STAT, 50, ok);
    check("s6_seen", {31'h0, ok}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_htrans", {30'h0, htrans}, 32'h0);
    check("s6_haddr", haddr, 32'h0);
    check("s6_hwdata", hwdata, 32'h0);
    check("s6_flags", {27'h0, hwrite, busy, done, err, timeout}, 32'h0);
    check("s6_state", {29'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    lock_n = 1;
    clear_logs();
    run_seq(32'h0000_0A05, 100, cyc);
    check("s6_cycles", cyc, 13);
    check("s6_done", {30'h0, done, err}, 32'h2);
    check("s6_nwr", n_wr, 3);
    check("s6_wd0", wr_data[0], 32'h0000_0A05);
    check("s6_wa2", wr_addr[2], A_SEL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
